// File: rtl/blink_period_meter.sv
// blink_period_meter: watches a same-clock blink signal, reports edges,
// period and high-phase length in cycles, rising-edge count, and flags a
// blinker that has stopped producing rising edges.
module blink_period_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic [CNT_W-1:0] high_len,
  output logic             stalled,
  output logic [7:0]       edge_cnt
);

  typedef enum logic [1:0] {SYNC, RUN, STALL} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  state_t           state, state_nx;
  logic             b0, b1;
  logic [CNT_W-1:0] timer;
  logic             timer_ld, timer_inc, per_ld, hl_ld, cnt_inc;

  // Edge detect from the two-stage sample pipe; both edges seen in any state.
  assign rise = b0 & ~b1;
  assign fall = ~b0 & b1;

  // Sample pipe for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      b0 <= 1'b0;
      b1 <= 1'b0;
    end else begin
      b0 <= blink;
      b1 <= b0;
    end
  end

  // Next-state and datapath controls. The first rise after SYNC or STALL
  // only restarts the timer: the interval behind it is not a real period.
  always_comb begin
    state_nx  = state;
    timer_ld  = 1'b0;
    timer_inc = 1'b0;
    per_ld    = 1'b0;
    hl_ld     = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      SYNC: begin
        if (rise) begin
          state_nx = RUN;
          timer_ld = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      RUN: begin
        hl_ld = fall;
        if (rise) begin
          // A rise landing on the timeout cycle still counts as a period.
          per_ld   = 1'b1;
          timer_ld = 1'b1;
          cnt_inc  = 1'b1;
        end else if (timer == TMO) begin
          state_nx = STALL;
        end else begin
          timer_inc = 1'b1;
        end
      end
      STALL: begin
        if (rise) begin
          state_nx = RUN;
          timer_ld = 1'b1;
          cnt_inc  = 1'b1;
        end
      end
      default: state_nx = SYNC;
    endcase
  end

  // State, timer and measurement registers. Timer freezes outside RUN and
  // never passes TIMEOUT, so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      timer      <= '0;
      period     <= '0;
      period_vld <= 1'b0;
      high_len   <= '0;
      stalled    <= 1'b0;
      edge_cnt   <= '0;
    end else begin
      state      <= state_nx;
      period_vld <= per_ld;
      stalled    <= (state_nx == STALL);
      if (timer_ld)       timer <= CNT_W'(1);
      else if (timer_inc) timer <= timer + CNT_W'(1);
      if (per_ld)  period   <= timer;
      if (hl_ld)   high_len <= timer;
      if (cnt_inc) edge_cnt <= edge_cnt + 8'd1;
    end
  end

endmodule

// File: doc/blink_period_meter.md
Name: blink_period_meter

Overview:
- Downstream consumer of the blinker stage; samples its single-bit `blink` output on the same clock.
- Detects rising and falling edges of `blink`.
- Measures blink period and high-phase length in clock cycles, counts rising edges, and flags a stalled blinker.
- Used as a self-check monitor on blink/LED outputs in simulation and on-chip.

Parameters:
- CNT_W, 8, width of the cycle timer, `period` and `high_len`.
- TIMEOUT, 200, cycles without a rising edge before `stalled` asserts; legal range 2..2^CNT_W-1.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- blink  in  1  blink signal from upstream stage, same clock domain (no synchroniser).
- rise  out  1  one-cycle pulse on detected rising edge.
- fall  out  1  one-cycle pulse on detected falling edge.
- period  out  CNT_W  cycles between the last two rising edges.
- period_vld  out  1  one-cycle pulse when `period` updates.
- high_len  out  CNT_W  cycles from the last rising edge to the following falling edge.
- stalled  out  1  high while no rising edge has occurred for TIMEOUT cycles.
- edge_cnt  out  8  rising-edge count, wraps modulo 256.

Behaviour:
- Reset (sync, rst=1 at posedge) clears all state:
  - b0=b1=0, timer=0, state=SYNC.
  - period=0, high_len=0, period_vld=0, stalled=0, edge_cnt=0.
  - rise and fall are 0 while b0=b1=0.
- Input pipeline: b0 <= blink; b1 <= b0 every cycle.
  - rise = b0 & ~b1; fall = ~b0 & b1 (combinational from flops).
  - If `blink` is sampled high at edge N, `rise` is high between edges N and N+1.
- Timer:
  - In RUN: on rise, timer <= 1; otherwise timer <= timer+1.
  - Cannot exceed TIMEOUT in RUN, so no wrap.
  - Frozen in SYNC and STALL.
- FSM states: SYNC, RUN, STALL.
- SYNC (after reset): waits for the first rise.
  - On rise: -> RUN, timer <= 1, edge_cnt+1, no period_vld.
- RUN:
  - On rise: period <= timer, period_vld <= 1 (next cycle only), timer <= 1, edge_cnt+1.
  - On fall: high_len <= timer. No valid strobe; holds until the next fall.
  - If timer == TIMEOUT and no rise this cycle: -> STALL, stalled <= 1.
  - Rise in the same cycle as timer == TIMEOUT wins: period <= TIMEOUT, period_vld, stay in RUN.
- STALL:
  - stalled stays 1; `period` and `high_len` hold their last values.
  - Falls are ignored (no high_len update).
  - On rise: -> RUN, stalled <= 0, timer <= 1, edge_cnt+1, no period_vld (interval invalid).
- Strobes: period_vld is registered and is never high in two consecutive cycles for a blink period ≥2.
- Latency: blink 0->1 sampled at edge N gives rise in cycle N..N+1, and period/period_vld visible after edge N+1.
- Reset mid-operation:
  - Immediate return to SYNC; all outputs at reset values next cycle.
  - If `blink` is held high through reset, a rise fires one cycle after rst deasserts and is treated as the first edge (no period_vld).
- edge_cnt wraps 255 -> 0 silently. rise/fall track the input in every state.

Test Plan:
1. Reset 3 cycles, then drive 4 cycles high / 4 cycles low (a 3-bit counter MSB) -> first rise: edge_cnt=1, no period_vld; every later rise: period_vld with period=8; high_len=4 after each fall.
2. Waveform 3 high / 7 low after sync -> period=10, high_len=3, period_vld exactly one cycle per period.
3. TIMEOUT=20: rise then hold blink low -> stalled=1 exactly 20 cycles after the post-rise timer load. Next rise -> stalled=0, no period_vld. Following rise 8 cycles later -> period=8.
4. TIMEOUT=20 with the rise landing exactly when timer==20 -> period_vld with period=20, stalled stays 0.
5. Assert rst for 1 cycle mid-RUN while blink is high -> all outputs cleared. Rise one cycle after release, edge_cnt=1, no period_vld. Next regular rise -> correct period.
6. 256 rising edges with period 8 -> edge_cnt returns to 0; period stays 8 throughout.
